flag_intr_ctrl: RTL and testbench

// - Sequencer and owner of the C/Z flag register's control strobes (SET/CLR/LD) and of the interrupt-enable flag.
// - Runs the MCU INIT/FETCH/EXEC/INTR state cycle.
// - Saves C/Z into shadow flags on interrupt entry; restores them on RETID/RETIE.
// - Sits between instruction decode and the flag register; also drives INTR_ACK toward the PC/stack sequencing logic.

---
 rtl/rat_flag_pkg.sv | 73 +++++++
 rtl/flag_intr_ctrl_intr_sync.sv | 44 ++++
 rtl/flag_intr_ctrl.sv | 133 +++++++++++++
 tb/tb_flag_intr_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rat_flag_pkg.sv
// Shared types for the flag/interrupt sequencer: state encoding, flag-effect
// opcode classes and the EXEC-cycle decode of an opcode class.
package rat_flag_pkg;

    localparam int OPC_CLASS_W = 4;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    typedef enum logic [OPC_CLASS_W-1:0] {
        OPC_NONE  = 4'd0,
        OPC_CZ    = 4'd1,
        OPC_Z     = 4'd2,
        OPC_C     = 4'd3,
        OPC_SETC  = 4'd4,
        OPC_CLRC  = 4'd5,
        OPC_SEI   = 4'd6,
        OPC_CLI   = 4'd7,
        OPC_RETID = 4'd8,
        OPC_RETIE = 4'd9
    } op_class_t;

    typedef enum logic [1:0] {
        IF_HOLD = 2'd0,
        IF_SET  = 2'd1,
        IF_CLR  = 2'd2
    } i_upd_t;

    typedef struct packed {
        logic c_set;
        logic c_clr;
        logic c_ld;
        logic z_ld;
        logic ld_sel;
    } flg_strobe_t;

    typedef struct packed {
        flg_strobe_t stb;
        i_upd_t      i_upd;
    } op_dec_t;

    function automatic op_dec_t decode_op(input op_class_t opc);
        op_dec_t dec;
        dec = '0;
        dec.i_upd = IF_HOLD;
        case (opc)
            OPC_CZ: begin
                dec.stb.c_ld = 1'b1;
                dec.stb.z_ld = 1'b1;
            end
            OPC_Z:    dec.stb.z_ld  = 1'b1;
            OPC_C:    dec.stb.c_ld  = 1'b1;
            OPC_SETC: dec.stb.c_set = 1'b1;
            OPC_CLRC: dec.stb.c_clr = 1'b1;
            OPC_SEI:  dec.i_upd     = IF_SET;
            OPC_CLI:  dec.i_upd     = IF_CLR;
            // Returns reload C/Z from the shadow copies through the flag mux.
            OPC_RETID, OPC_RETIE: begin
                dec.stb.ld_sel = 1'b1;
                dec.stb.c_ld   = 1'b1;
                dec.stb.z_ld   = 1'b1;
                dec.i_upd      = (opc == OPC_RETIE) ? IF_SET : IF_CLR;
            end
            default: dec = '0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/flag_intr_ctrl_intr_sync.sv
// External interrupt input: multi-flop synchronizer, rising-edge detect and a
// pending latch that the sequencer clears when it enters the INTR state.
module intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic INTR,
    input  logic CLR_PEND,
    output logic PEND
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   edge_q;
    logic                   edge_d;
    logic                   pend_q;
    logic                   pend_d;
    logic                   rise;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = INTR;
        edge_d    = sync_q[SYNC_STAGES-1];
        rise      = sync_q[SYNC_STAGES-1] & ~edge_q;
        // A new edge in the same cycle as the clear must not be lost.
        pend_d    = rise | (pend_q & ~CLR_PEND);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
            pend_q <= pend_d;
        end
    end

    assign PEND = pend_q;

endmodule

// File: rtl/flag_intr_ctrl.sv
// MCU INIT/FETCH/EXEC/INTR sequencer: drives the C/Z flag register strobes,
// owns the interrupt-enable flag and the single-level C/Z shadow copy.
module flag_intr_ctrl
    import rat_flag_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OPC_W       = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             INTR,
    input  logic [OPC_W-1:0] OP_CLASS,
    input  logic             C_FLAG,
    input  logic             Z_FLAG,
    output logic             FLG_C_SET,
    output logic             FLG_C_CLR,
    output logic             FLG_C_LD,
    output logic             FLG_Z_LD,
    output logic             FLG_LD_SEL,
    output logic             SHAD_C,
    output logic             SHAD_Z,
    output logic             I_FLAG,
    output logic             INTR_ACK,
    output logic [1:0]       STATE
);

    state_t      state_q, state_d;
    logic        i_flag_q, i_flag_d;
    logic        shad_c_q, shad_c_d;
    logic        shad_z_q, shad_z_d;
    logic        pend;
    logic        clr_pend;
    logic        intr_ack;
    op_class_t   opc_e;
    op_dec_t     dec;
    flg_strobe_t stb;

    intr_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_intr_sync (
        .CLK      (CLK),
        .RST      (RST),
        .INTR     (INTR),
        .CLR_PEND (clr_pend),
        .PEND     (pend)
    );

    // Codes outside the defined class list decode as OPC_NONE.
    always_comb begin
        opc_e = OPC_NONE;
        if (OP_CLASS <= OPC_W'(OPC_RETIE)) begin
            opc_e = op_class_t'(OP_CLASS[OPC_CLASS_W-1:0]);
        end
        dec = decode_op(opc_e);
    end

    always_comb begin
        state_d  = state_q;
        i_flag_d = i_flag_q;
        shad_c_d = shad_c_q;
        shad_z_d = shad_z_q;
        stb      = '0;
        intr_ack = 1'b0;
        clr_pend = 1'b0;

        case (state_q)
            ST_INIT: begin
                stb.ld_sel = 1'b1;
                stb.c_ld   = 1'b1;
                stb.z_ld   = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                stb = dec.stb;
                case (dec.i_upd)
                    IF_SET:  i_flag_d = 1'b1;
                    IF_CLR:  i_flag_d = 1'b0;
                    default: i_flag_d = i_flag_q;
                endcase
                // Take decision uses the enable as it stood before this instruction.
                if (pend && i_flag_q) begin
                    state_d  = ST_INTR;
                    clr_pend = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_INTR: begin
                intr_ack = 1'b1;
                shad_c_d = C_FLAG;
                shad_z_d = Z_FLAG;
                i_flag_d = 1'b0;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_INIT;
        endcase

        if (RST) begin
            stb      = '0;
            intr_ack = 1'b0;
            clr_pend = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_INIT;
            i_flag_q <= 1'b0;
            shad_c_q <= 1'b0;
            shad_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_flag_q <= i_flag_d;
            shad_c_q <= shad_c_d;
            shad_z_q <= shad_z_d;
        end
    end

    assign FLG_C_SET  = stb.c_set;
    assign FLG_C_CLR  = stb.c_clr;
    assign FLG_C_LD   = stb.c_ld;
    assign FLG_Z_LD   = stb.z_ld;
    assign FLG_LD_SEL = stb.ld_sel;
    assign SHAD_C     = shad_c_q;
    assign SHAD_Z     = shad_z_q;
    assign I_FLAG     = i_flag_q;
    assign INTR_ACK   = intr_ack;
    assign STATE      = state_q;

endmodule

// File: tb/tb_flag_intr_ctrl.sv
// Scoreboard bench for flag_intr_ctrl: a behavioural model predicts each
// cycle's outputs into a queue, a negedge monitor pops and compares.
module tb_flag_intr_ctrl;
    import rat_flag_pkg::*;

    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       INTR = 1'b0;
    logic [3:0] OP_CLASS = 4'd0;
    logic       C_FLAG = 1'b0;
    logic       Z_FLAG = 1'b0;
    logic       FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL;
    logic       SHAD_C, SHAD_Z, I_FLAG, INTR_ACK;
    logic [1:0] STATE;

    flag_intr_ctrl #(
        .SYNC_STAGES (S),
        .OPC_W       (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .INTR       (INTR),
        .OP_CLASS   (OP_CLASS),
        .C_FLAG     (C_FLAG),
        .Z_FLAG     (Z_FLAG),
        .FLG_C_SET  (FLG_C_SET),
        .FLG_C_CLR  (FLG_C_CLR),
        .FLG_C_LD   (FLG_C_LD),
        .FLG_Z_LD   (FLG_Z_LD),
        .FLG_LD_SEL (FLG_LD_SEL),
        .SHAD_C     (SHAD_C),
        .SHAD_Z     (SHAD_Z),
        .I_FLAG     (I_FLAG),
        .INTR_ACK   (INTR_ACK),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] st;
        logic       c_set;
        logic       c_clr;
        logic       c_ld;
        logic       z_ld;
        logic       ld_sel;
        logic       shad_c;
        logic       shad_z;
        logic       i_flag;
        logic       ack;
        logic       ack_chk;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model: state as 0=INIT 1=FETCH 2=EXEC 3=INTR; ih[k] = INTR level k cycles ago.
    int   m_st = 0;
    bit   m_i = 0, m_sc = 0, m_sz = 0, m_pend = 0;
    bit   ih[0:15];
    bit   intr_lvl = 0, cf_lvl = 0, zf_lvl = 0;

    task automatic step(input bit r, input bit i, input logic [3:0] o);
        exp_t e;
        bit   rise, take;
        int   nst;
        @(posedge CLK);
        #1;
        RST = r; INTR = i; OP_CLASS = o; C_FLAG = cf_lvl; Z_FLAG = zf_lvl;
        for (int k = 15; k > 0; k--) ih[k] = ih[k-1];
        ih[0] = i;

        e = '0;
        e.st = 2'(m_st);
        e.shad_c = m_sc; e.shad_z = m_sz; e.i_flag = m_i;
        e.ack_chk = !r;
        if (!r) begin
            case (m_st)
                0: begin e.ld_sel = 1; e.c_ld = 1; e.z_ld = 1; end
                2: begin
                    case (o)
                        OPC_CZ:   begin e.c_ld = 1; e.z_ld = 1; end
                        OPC_Z:    e.z_ld = 1;
                        OPC_C:    e.c_ld = 1;
                        OPC_SETC: e.c_set = 1;
                        OPC_CLRC: e.c_clr = 1;
                        OPC_RETID, OPC_RETIE: begin e.ld_sel = 1; e.c_ld = 1; e.z_ld = 1; end
                        default: ;
                    endcase
                end
                3: e.ack = 1;
                default: ;
            endcase
        end
        exp_q.push_back(e);

        if (r) begin
            m_st = 0; m_i = 0; m_sc = 0; m_sz = 0; m_pend = 0;
            for (int k = 0; k < 16; k++) ih[k] = 0;
        end else begin
            rise = ih[S] && !ih[S+1];
            take = (m_st == 2) && m_pend && m_i;
            case (m_st)
                0: nst = 1;
                1: nst = 2;
                2: nst = take ? 3 : 1;
                default: nst = 1;
            endcase
            if (m_st == 2) begin
                if (o == OPC_SEI || o == OPC_RETIE) m_i = 1;
                if (o == OPC_CLI || o == OPC_RETID) m_i = 0;
            end
            if (m_st == 3) begin
                m_i = 0; m_sc = cf_lvl; m_sz = zf_lvl;
            end
            m_pend = rise ? 1'b1 : (take ? 1'b0 : m_pend);
            m_st = nst;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, intr_lvl, OPC_NONE);
    endtask

    // Hold the opcode on the bus until an EXEC cycle has consumed it.
    task automatic do_op(input logic [3:0] o);
        int s;
        for (int k = 0; k < 12; k++) begin
            s = m_st;
            step(0, intr_lvl, o);
            if (s == 2) break;
        end
    endtask

    task automatic pulse(input int n_hi);
        intr_lvl = 1;
        idle(n_hi);
        intr_lvl = 0;
    endtask

    always @(negedge CLK) begin
        exp_t e, a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {STATE, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL,
                 SHAD_C, SHAD_Z, I_FLAG, INTR_ACK, e.ack_chk};
            if (!e.ack_chk) a.ack = e.ack;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cyc=%0d outputs: got st=%0d set=%b clr=%b cld=%b zld=%b sel=%b shc=%b shz=%b i=%b ack=%b, need st=%0d set=%b clr=%b cld=%b zld=%b sel=%b shc=%b shz=%b i=%b ack=%b",
                         cyc, a.st, a.c_set, a.c_clr, a.c_ld, a.z_ld, a.ld_sel, a.shad_c, a.shad_z, a.i_flag, a.ack,
                         e.st, e.c_set, e.c_clr, e.c_ld, e.z_ld, e.ld_sel, e.shad_c, e.shad_z, e.i_flag, e.ack);
            end
        end
    end

    initial begin
        for (int k = 0; k < 16; k++) ih[k] = 0;

        // Reset, then INIT and the FETCH/EXEC alternation.
        step(1, 0, OPC_NONE);
        step(1, 0, OPC_NONE);
        idle(6);

        // CZ held through FETCH and EXEC.
        for (int k = 0; k < 4; k++) step(0, 0, OPC_CZ);

        // Enable, then interrupt with C=1 Z=0.
        do_op(OPC_SEI);
        cf_lvl = 1; zf_lvl = 0;
        pulse(2);
        idle(10);

        // Interrupt while disabled stays pending until after the instruction following SEI.
        pulse(1);
        idle(10);
        do_op(OPC_SEI);
        do_op(OPC_NONE);
        idle(4);

        // Capture C=Z=1 into the shadow, then return with RETIE and single-bit ops.
        cf_lvl = 1; zf_lvl = 1;
        do_op(OPC_SEI);
        pulse(2);
        idle(8);
        cf_lvl = 0; zf_lvl = 0;
        do_op(OPC_RETIE);
        do_op(OPC_SETC);
        do_op(OPC_CLRC);
        do_op(OPC_C);
        do_op(OPC_Z);
        do_op(OPC_CLI);
        do_op(OPC_RETID);
        do_op(4'd13);

        // Reset during INTR with a second edge already in flight.
        do_op(OPC_SEI);
        intr_lvl = 1; idle(1);
        intr_lvl = 0; idle(1);
        intr_lvl = 1; idle(1);
        for (int k = 0; k < 20; k++) begin
            if (m_st == 3) begin
                intr_lvl = 0;
                step(1, 0, OPC_NONE);
                break;
            end
            step(0, intr_lvl, OPC_NONE);
        end
        intr_lvl = 0;
        idle(4);
        do_op(OPC_SEI);
        idle(10);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) intr_lvl = ~intr_lvl;
            cf_lvl = 1'($urandom_range(0, 1));
            zf_lvl = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 99) == 0), intr_lvl, 4'($urandom_range(0, 15)));
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge CLK);
        @(posedge CLK);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
